npc_mem_responder: RTL and testbench
====================================

// Module: npc_mem_responder
// PURPOSE
//  Memory-side counterpart of the npc core interface. It answers the core's instruction
//  ready/valid fetch handshake from a word-addressed array, and serves the core's data
//  port: synchronous stores, combinational loads, funct3-encoded size/sign.
//  It detects ebreak (32'h00100073), stops issuing instructions, and counts retired fetches.
//  It sits beside npc in the simulation top and replaces the C++ memory model.
// PARAMETERS
//  DEPTH_W    12            log2 of array depth in 32-bit words (4096 words = 16 KiB)
//  BASE_ADDR  32'h8000_0000 byte address of word 0
//  FETCH_LAT  1             cycles from fetch accept to inst_valid; must be >=1 and <=15
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  inst_addr    in   32  core PC; sampled when a fetch is accepted
//  inst_ready   in   1   core can accept an instruction
//  inst_valid   out  1   inst_bits holds a valid instruction
//  inst_bits    out  32  fetched instruction word
//  mem_wraddr   in   32  data byte address, shared by load and store
//  mem_wop      in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_wen      in   1   store strobe, one store per cycle when high
//  mem_wdata    in   32  store data, LSB-aligned
//  mem_rdata    out  32  load result, combinational, extended per mem_wop
//  prog_wen     in   1   preload word-write strobe (testbench / loader)
//  prog_addr    in   32  preload byte address, word aligned
//  prog_data    in   32  preload word
//  halted       out  1   ebreak has been handed to the core
//  inst_cnt     out  32  number of completed fetch handshakes
//  addr_err     out  1   one-cycle pulse: out-of-range or misaligned access
// BEHAVIOUR
//  Reset values: inst_valid=0, inst_bits=0, halted=0, inst_cnt=0, addr_err=0, FSM=IDLE.
//   Array contents are not reset.
//  Word index = (addr - BASE_ADDR) >> 2. An address is in range if addr-BASE_ADDR < 4<<DEPTH_W.
//  FSM states are IDLE, WAIT, VALID, HALT.
//   IDLE : on inst_ready=1, latch the word index from inst_addr and load lat_cnt=FETCH_LAT-1.
//          Go to VALID if FETCH_LAT==1, else to WAIT.
//   WAIT : decrement lat_cnt. When lat_cnt==0, go to VALID. inst_ready dropping has no effect.
//   VALID: inst_valid=1. inst_bits is driven from a register holding the array word read at
//          entry, and stays stable until the handshake completes.
//          On inst_valid&&inst_ready: inst_cnt+=1 (wraps at 2^32).
//          Then go to HALT if inst_bits==EBREAK, else to IDLE. inst_valid drops the next cycle.
//   HALT : halted=1, inst_valid=0 permanently. Only rst leaves HALT.
//  Minimum fetch-to-fetch spacing is FETCH_LAT+1 cycles (IDLE cycle plus latency).
//  Out-of-range fetch: inst_bits=32'h00000013 (nop), addr_err pulses on entry to VALID,
//   and the handshake proceeds normally.
//  Stores are written on the clk edge where mem_wen=1.
//   Byte-enable mask and data are lane-shifted by addr[1:0]:
//   B -> 1 lane, H -> 2 lanes (addr[0] must be 0), W -> 4 lanes (addr[1:0] must be 0).
//   Misaligned or out-of-range store: nothing is written, addr_err pulses the next cycle.
//   Encodings 011, 110 and 111 are treated as W.
//  Loads: mem_rdata comes combinationally from the array word, shifted by addr[1:0].
//   B/H sign-extend, BU/HU zero-extend, W passes through.
//   Misaligned or out-of-range load returns 0 (no addr_err; the core may probe speculatively).
//   A load does not see a same-cycle store; it sees it from the next cycle.
//  prog_wen writes a full word and takes priority over mem_wen when both target the same
//   word in one cycle (the store is dropped). It is allowed in any state.
//  Async rst mid-WAIT or mid-VALID aborts the fetch: inst_valid falls immediately,
//   inst_cnt clears, and array contents persist.
// STRUCTURE
//  Package npc_mem_pkg: MEMOP_B/H/W/BU/HU localparams, EBREAK=32'h00100073,
//   NOP=32'h00000013, fetch-FSM state encoding.
//  Sub-module npc_mem_align (combinational): from memop, addr[1:0] and wdata, produce the
//   4-bit byte-enable, the aligned store data and the misalign flag. It also load-extends
//   a raw word into mem_rdata.
//  Top: the array (reg [31:0] mem [0:2**DEPTH_W-1]), the fetch FSM, lat_cnt, inst_cnt,
//   and the addr_err register.
// TESTING
//  1. FETCH_LAT=1. Preload 0x80000000=0x00500093. inst_addr=0x80000000, inst_ready=1
//     -> inst_valid rises 1 cycle after accept with inst_bits=0x00500093; inst_cnt=1 after the handshake.
//  2. FETCH_LAT=3. Hold inst_ready=0 while in VALID for 5 cycles
//     -> inst_bits stays stable, inst_cnt unchanged until ready rises.
//  3. Store B 0xAB at 0x80000101, then load B and BU at the same address
//     -> mem_rdata=0xFFFFFFAB, then 0x000000AB; the other bytes of the word are unchanged.
//  4. Store H at 0x80000003 -> no write, addr_err pulses once.
//     Fetch at 0x7FFFFFFC -> inst_bits=0x00000013, addr_err pulses.
//  5. Fetch a word equal to 0x00100073 -> halted=1 after the handshake, inst_valid stays 0
//     for 20 cycles despite inst_ready=1.
//  6. Assert rst mid-WAIT -> inst_valid=0 and inst_cnt=0 asynchronously;
//     after release, a fresh fetch of a preloaded word still returns its value.

Source files
------------

// File: rtl/npc_mem_pkg.sv
// Shared encodings for the npc memory responder: load/store funct3 codes,
// special instruction words and the fetch FSM state type.
package npc_mem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StValid = 2'd2,
    StHalt  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/npc_mem_align.sv
// Data-port lane logic: byte enables, lane-shifted store data, misalignment
// detection and load extension of a raw array word.
module npc_mem_align
  import npc_mem_pkg::*;
(
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_shamt;
  logic [31:0] w_rshift;

  assign w_shamt  = {i_addr_lo, 3'b000};
  assign w_rshift = i_rword >> w_shamt;

  // Decode access size, lanes and load extension from funct3.
  always_comb begin
    o_be       = '0;
    o_misalign = 1'b0;
    o_rdata    = '0;
    o_wdata    = i_wdata << w_shamt;
    unique case (i_memop)
      MEMOP_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_rdata = {{24{w_rshift[7]}}, w_rshift[7:0]};
      end
      MEMOP_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_rdata = {24'h0, w_rshift[7:0]};
      end
      MEMOP_H: begin
        o_misalign = i_addr_lo[0];
        o_be       = 4'b0011 << i_addr_lo;
        o_rdata    = {{16{w_rshift[15]}}, w_rshift[15:0]};
      end
      MEMOP_HU: begin
        o_misalign = i_addr_lo[0];
        o_be       = 4'b0011 << i_addr_lo;
        o_rdata    = {16'h0, w_rshift[15:0]};
      end
      // MEMOP_W and the unused encodings all behave as a word access.
      default: begin
        o_misalign = |i_addr_lo;
        o_be       = 4'b1111;
        o_rdata    = w_rshift;
      end
    endcase
    if (o_misalign) begin
      o_be    = '0;
      o_rdata = '0;
    end
  end

endmodule

// File: rtl/npc_mem_responder.sv
// Memory-side partner of the npc core: instruction fetch handshake with a
// configurable latency, a byte-addressable data port and a preload port.
module npc_mem_responder
  import npc_mem_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 12,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned FETCH_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst_addr,
  input  logic        i_inst_ready,
  output logic        o_inst_valid,
  output logic [31:0] o_inst_bits,
  input  logic [31:0] i_mem_wraddr,
  input  logic [2:0]  i_mem_wop,
  input  logic        i_mem_wen,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  input  logic        i_prog_wen,
  input  logic [31:0] i_prog_addr,
  input  logic [31:0] i_prog_data,
  output logic        o_halted,
  output logic [31:0] o_inst_cnt,
  output logic        o_addr_err
);

  localparam int unsigned Words     = 2 ** DEPTH_W;
  localparam logic [31:0] SpanBytes = 32'(4) << DEPTH_W;

  logic [31:0] r_mem [0:Words-1];

  fetch_state_e       r_state, w_state_d;
  logic [3:0]         r_lat_cnt, w_lat_d;
  logic [DEPTH_W-1:0] r_idx;
  logic               r_idx_ok;
  logic [31:0]        r_inst_bits;
  logic [31:0]        r_inst_cnt;
  logic               r_addr_err;

  logic               w_latch, w_enter_valid, w_handshake;

  // Address decode for the three ports.
  logic [31:0]        w_f_off, w_d_off, w_p_off;
  logic               w_f_ok, w_d_ok, w_p_ok;
  logic [DEPTH_W-1:0] w_f_idx, w_d_idx, w_p_idx;

  assign w_f_off = i_inst_addr - BASE_ADDR;
  assign w_d_off = i_mem_wraddr - BASE_ADDR;
  assign w_p_off = i_prog_addr - BASE_ADDR;
  assign w_f_ok  = w_f_off < SpanBytes;
  assign w_d_ok  = w_d_off < SpanBytes;
  assign w_p_ok  = w_p_off < SpanBytes;
  assign w_f_idx = DEPTH_W'(w_f_off >> 2);
  assign w_d_idx = DEPTH_W'(w_d_off >> 2);
  assign w_p_idx = DEPTH_W'(w_p_off >> 2);

  logic [3:0]  w_be;
  logic [31:0] w_wdata_al, w_ld_data, w_d_word;
  logic        w_misalign, w_st_ok, w_st_drop;

  assign w_d_word = r_mem[w_d_idx];

  npc_mem_align u_align (
    .i_memop    (i_mem_wop),
    .i_addr_lo  (i_mem_wraddr[1:0]),
    .i_wdata    (i_mem_wdata),
    .i_rword    (w_d_word),
    .o_be       (w_be),
    .o_wdata    (w_wdata_al),
    .o_misalign (w_misalign),
    .o_rdata    (w_ld_data)
  );

  assign o_mem_rdata = w_d_ok ? w_ld_data : 32'h0;
  assign w_st_ok     = i_mem_wen && w_d_ok && !w_misalign;
  // A preload to the same word wins; the store is dropped entirely.
  assign w_st_drop   = i_prog_wen && w_p_ok && (w_p_idx == w_d_idx);

  // Array writes: lane-masked stores and full-word preloads (contents never reset).
  always_ff @(posedge i_clk) begin
    if (w_st_ok && !w_st_drop) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_d_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
      end
    end
    if (i_prog_wen && w_p_ok) r_mem[w_p_idx] <= i_prog_data;
  end

  // Word captured on entry to VALID: straight from inst_addr when leaving IDLE.
  logic [DEPTH_W-1:0] w_sel_idx;
  logic               w_sel_ok;
  logic [31:0]        w_fetch_word;

  assign w_sel_idx    = (r_state == StIdle) ? w_f_idx : r_idx;
  assign w_sel_ok     = (r_state == StIdle) ? w_f_ok : r_idx_ok;
  assign w_fetch_word = w_sel_ok ? r_mem[w_sel_idx] : NOP;

  // Fetch FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Fetch FSM next state; lat_cnt reaches zero on the WAIT->VALID transition.
  always_comb begin
    w_state_d     = r_state;
    w_lat_d       = r_lat_cnt;
    w_latch       = 1'b0;
    w_enter_valid = 1'b0;
    w_handshake   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_inst_ready) begin
          w_latch = 1'b1;
          w_lat_d = 4'(FETCH_LAT - 1);
          if (FETCH_LAT == 1) begin
            w_state_d     = StValid;
            w_enter_valid = 1'b1;
          end else begin
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        w_lat_d = r_lat_cnt - 4'd1;
        if (r_lat_cnt == 4'd1) begin
          w_state_d     = StValid;
          w_enter_valid = 1'b1;
        end
      end
      StValid: begin
        if (i_inst_ready) begin
          w_handshake = 1'b1;
          w_state_d   = (r_inst_bits == EBREAK) ? StHalt : StIdle;
        end
      end
      default: w_state_d = StHalt;
    endcase
  end

  // Fetch datapath, retire counter and the address-error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lat_cnt   <= '0;
      r_idx       <= '0;
      r_idx_ok    <= 1'b0;
      r_inst_bits <= '0;
      r_inst_cnt  <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_lat_cnt <= w_lat_d;
      if (w_latch) begin
        r_idx    <= w_f_idx;
        r_idx_ok <= w_f_ok;
      end
      if (w_enter_valid) r_inst_bits <= w_fetch_word;
      if (w_handshake)   r_inst_cnt  <= r_inst_cnt + 32'd1;
      r_addr_err <= (w_enter_valid && !w_sel_ok) || (i_mem_wen && (!w_d_ok || w_misalign));
    end
  end

  assign o_inst_valid = (r_state == StValid);
  assign o_halted     = (r_state == StHalt);
  assign o_inst_bits  = r_inst_bits;
  assign o_inst_cnt   = r_inst_cnt;
  assign o_addr_err   = r_addr_err;

endmodule

// File: tb/tb_npc_mem_responder.sv
// Self-checking bench for npc_mem_responder: a FETCH_LAT=3 instance carries most
// scenarios, a FETCH_LAT=1 instance checks single-cycle latency.
module tb_npc_mem_responder;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          LAT    = 3;
  localparam int          NWORDS = 4096;
  localparam logic [31:0] SPAN   = 32'd16384;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] NOPW   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_addr = '0, inst_addr1 = '0;
  logic        inst_ready = 1'b0, inst_ready1 = 1'b0;
  logic        inst_valid, inst_valid1;
  logic [31:0] inst_bits, inst_bits1;
  logic [31:0] mem_wraddr = '0;
  logic [2:0]  mem_wop = '0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata, mem_rdata1;
  logic        prog_wen = 1'b0;
  logic [31:0] prog_addr = '0, prog_data = '0;
  logic        halted, halted1, addr_err, addr_err1;
  logic [31:0] inst_cnt, inst_cnt1;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_mem [0:NWORDS-1];
  logic [31:0] exp_cnt = '0;

  always #5 clk = ~clk;

  npc_mem_responder #(.DEPTH_W(12), .BASE_ADDR(BASE), .FETCH_LAT(LAT)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_inst_addr(inst_addr), .i_inst_ready(inst_ready),
    .o_inst_valid(inst_valid), .o_inst_bits(inst_bits), .i_mem_wraddr(mem_wraddr),
    .i_mem_wop(mem_wop), .i_mem_wen(mem_wen), .i_mem_wdata(mem_wdata),
    .o_mem_rdata(mem_rdata), .i_prog_wen(prog_wen), .i_prog_addr(prog_addr),
    .i_prog_data(prog_data), .o_halted(halted), .o_inst_cnt(inst_cnt), .o_addr_err(addr_err)
  );

  npc_mem_responder #(.DEPTH_W(12), .BASE_ADDR(BASE), .FETCH_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_inst_addr(inst_addr1), .i_inst_ready(inst_ready1),
    .o_inst_valid(inst_valid1), .o_inst_bits(inst_bits1), .i_mem_wraddr(mem_wraddr),
    .i_mem_wop(mem_wop), .i_mem_wen(mem_wen), .i_mem_wdata(mem_wdata),
    .o_mem_rdata(mem_rdata1), .i_prog_wen(prog_wen), .i_prog_addr(prog_addr),
    .i_prog_data(prog_data), .o_halted(halted1), .o_inst_cnt(inst_cnt1),
    .o_addr_err(addr_err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes implied by funct3.
  function automatic int op_size(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] op);
    logic [31:0] off, v;
    int lane, sz;
    off = addr - BASE;
    if (off >= SPAN) return 32'h0;
    lane = int'(off % 4);
    sz = op_size(op);
    if (lane % sz != 0) return 32'h0;
    v = model_mem[off / 4] >> (8 * lane);
    if (sz == 1) begin
      v = v % 256;
      if (!op[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v % 65536;
      if (!op[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Applies a store to the model; returns 1 when the access is rejected.
  function automatic bit ref_store(input logic [31:0] addr, input logic [2:0] op,
                                   input logic [31:0] data);
    logic [31:0] off, w, bmask, byte_v;
    int lane, sz;
    off = addr - BASE;
    if (off >= SPAN) return 1'b1;
    lane = int'(off % 4);
    sz = op_size(op);
    if (lane % sz != 0) return 1'b1;
    w = model_mem[off / 4];
    for (int k = 0; k < sz; k++) begin
      byte_v = (data >> (8 * k)) & 32'hFF;
      bmask = 32'hFF << (8 * (lane + k));
      w = (w & ~bmask) | (byte_v << (8 * (lane + k)));
    end
    model_mem[off / 4] = w;
    return 1'b0;
  endfunction

  task automatic prog_word(input logic [31:0] addr, input logic [31:0] data);
    prog_wen = 1'b1; prog_addr = addr; prog_data = data;
    tick();
    prog_wen = 1'b0;
    model_mem[(addr - BASE) / 4] = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0 || inst_bits !== 32'h0 || halted !== 1'b0 || inst_cnt !== 32'h0 ||
        addr_err !== 1'b0)
      begin
        n_errors++;
        $display("FAIL reset: valid=%b bits=%h halted=%b cnt=%0d err=%b, required all zero",
                 inst_valid, inst_bits, halted, inst_cnt, addr_err);
      end
    tick();
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic preload_all();
    logic [31:0] d;
    for (int i = 0; i < NWORDS; i++) begin
      d = $urandom;
      if (d == EBRK) d = NOPW;
      prog_word(BASE + 32'(4 * i), d);
    end
  endtask

  task automatic test_fetch_lat1();
    prog_word(BASE, 32'h0050_0093);
    inst_addr1 = BASE; inst_ready1 = 1'b1;
    n_checks++;
    if (inst_valid1 !== 1'b0) begin
      n_errors++; $display("FAIL lat1_before: valid=%b required 0", inst_valid1);
    end
    tick();
    n_checks++;
    if (inst_valid1 !== 1'b1 || inst_bits1 !== 32'h0050_0093) begin
      n_errors++;
      $display("FAIL lat1_valid: valid=%b bits=%h required 1/00500093", inst_valid1, inst_bits1);
    end
    tick();
    inst_ready1 = 1'b0;
    n_checks++;
    if (inst_cnt1 !== 32'd1 || inst_valid1 !== 1'b0) begin
      n_errors++;
      $display("FAIL lat1_cnt: cnt=%0d valid=%b required 1/0", inst_cnt1, inst_valid1);
    end
  endtask

  // One complete fetch on the LAT=3 instance, holding ready low for 'hold' VALID cycles.
  task automatic test_fetch(input logic [31:0] addr, input int hold);
    logic [31:0] off, exp_bits;
    bit ok;
    int n;
    off = addr - BASE;
    ok = off < SPAN;
    exp_bits = ok ? model_mem[off / 4] : NOPW;
    inst_addr = addr; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n = 1;
    while (inst_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != LAT || inst_valid !== 1'b1) begin
      n_errors++; $display("FAIL fetch_latency: %0d cycles, required %0d", n, LAT);
    end
    n_checks++;
    if (inst_bits !== exp_bits) begin
      n_errors++; $display("FAIL fetch_bits @%h: got %h required %h", addr, inst_bits, exp_bits);
    end
    n_checks++;
    if (addr_err !== !ok) begin
      n_errors++; $display("FAIL fetch_addr_err @%h: got %b required %b", addr, addr_err, !ok);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_bits !== exp_bits || inst_cnt !== exp_cnt ||
          addr_err !== 1'b0) begin
        n_errors++;
        $display("FAIL fetch_hold: valid=%b bits=%h cnt=%0d err=%b required 1/%h/%0d/0",
                 inst_valid, inst_bits, inst_cnt, addr_err, exp_bits, exp_cnt);
      end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    n_checks++;
    if (inst_cnt !== exp_cnt || inst_valid !== 1'b0 || halted !== (exp_bits == EBRK)) begin
      n_errors++;
      $display("FAIL fetch_done: cnt=%0d valid=%b halted=%b required %0d/0/%b",
               inst_cnt, inst_valid, halted, exp_cnt, exp_bits == EBRK);
    end
  endtask

  task automatic test_fetch_random();
    logic [31:0] a;
    test_fetch(BASE, 5);
    for (int i = 0; i < 6; i++) begin
      a = BASE + 32'(4 * $urandom_range(0, NWORDS - 1));
      test_fetch(a, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic check_loads(input logic [31:0] addr);
    logic [2:0] ops [5];
    logic [31:0] e;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100; ops[4] = 3'b101;
    mem_wen = 1'b0;
    mem_wraddr = addr;
    for (int k = 0; k < 5; k++) begin
      mem_wop = ops[k];
      #1;
      e = ref_load(addr, ops[k]);
      n_checks++;
      if (mem_rdata !== e) begin
        n_errors++;
        $display("FAIL load @%h op=%b: got %h required %h", addr, ops[k], mem_rdata, e);
      end
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] d);
    logic [31:0] pre;
    bit exp_err;
    mem_wraddr = addr; mem_wop = op; mem_wdata = d; mem_wen = 1'b1;
    #1;
    if (op != 3'b011 && op[2:1] != 2'b11) begin
      pre = ref_load(addr, op);
      n_checks++;
      if (mem_rdata !== pre) begin
        n_errors++;
        $display("FAIL same_cycle_load @%h: got %h required %h", addr, mem_rdata, pre);
      end
    end
    tick();
    mem_wen = 1'b0;
    exp_err = ref_store(addr, op, d);
    n_checks++;
    if (addr_err !== exp_err) begin
      n_errors++;
      $display("FAIL store_addr_err @%h op=%b: got %b required %b", addr, op, addr_err, exp_err);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] a;
    do_store(32'h8000_0101, 3'b000, {$urandom_range(0, 255), 24'h0000AB} | 32'hAB);
    mem_wraddr = 32'h8000_0101; mem_wop = 3'b000;
    #1;
    n_checks++;
    if (mem_rdata !== 32'hFFFF_FFAB) begin
      n_errors++; $display("FAIL load_b_sign: got %h required ffffffab", mem_rdata);
    end
    mem_wop = 3'b100;
    #1;
    n_checks++;
    if (mem_rdata !== 32'h0000_00AB) begin
      n_errors++; $display("FAIL load_bu_zero: got %h required 000000ab", mem_rdata);
    end
    check_loads(32'h8000_0100);
    for (int i = 0; i < 30; i++) begin
      a = BASE + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = BASE + SPAN - 32'd4 + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = BASE - 32'd4 + 32'($urandom_range(0, 3));
      do_store(a, 3'($urandom_range(0, 7)), $urandom);
      check_loads({a[31:2], 2'b00} + 32'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_misalign_oob();
    do_store(32'h8000_0003, 3'b001, 32'h1234_5678);
    tick();
    n_checks++;
    if (addr_err !== 1'b0) begin
      n_errors++; $display("FAIL addr_err_one_pulse: got %b required 0", addr_err);
    end
    check_loads(32'h8000_0000);
    test_fetch(32'h7FFF_FFFC, 1);
  endtask

  task automatic test_prog_priority();
    logic [31:0] d;
    d = $urandom;
    if (d == EBRK) d = NOPW;
    prog_wen = 1'b1; prog_addr = BASE + 32'h40; prog_data = d;
    mem_wen = 1'b1; mem_wraddr = BASE + 32'h41; mem_wop = 3'b000; mem_wdata = ~d;
    tick();
    prog_wen = 1'b0; mem_wen = 1'b0;
    model_mem[16] = d;
    check_loads(BASE + 32'h40);
  endtask

  task automatic test_halt();
    prog_word(BASE + 32'h200, EBRK);
    test_fetch(BASE + 32'h200, 2);
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (inst_valid !== 1'b0 || halted !== 1'b1 || inst_cnt !== exp_cnt) begin
        n_errors++;
        $display("FAIL halt_hold: valid=%b halted=%b cnt=%0d required 0/1/%0d",
                 inst_valid, halted, inst_cnt, exp_cnt);
      end
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    rst = 1'b1; #1; rst = 1'b0;
    exp_cnt = '0;
    n_checks++;
    if (halted !== 1'b0) begin
      n_errors++; $display("FAIL reset_leaves_halt: halted=%b required 0", halted);
    end
    test_fetch(BASE + 32'h10, 0);
    inst_addr = BASE + 32'h20; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0 || inst_cnt !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid_wait: valid=%b cnt=%0d required 0/0", inst_valid, inst_cnt);
    end
    #1 rst = 1'b0;
    exp_cnt = '0;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (inst_valid !== 1'b1) begin
      n_errors++; $display("FAIL pre_reset_valid: valid=%b required 1", inst_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid_valid: valid=%b required 0", inst_valid);
    end
    #1 rst = 1'b0;
    test_fetch(BASE + 32'h20, 1);
  endtask

  initial begin
    test_reset();
    preload_all();
    test_fetch_lat1();
    test_fetch_random();
    test_store_load();
    test_misalign_oob();
    test_prog_priority();
    test_halt();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
